// File: rtl/wb_capture_ctrl.sv
// wb_capture_ctrl: Wishbone-controlled camera frame capture sequencer.
// Arms on START, opens the stream gate (enable_o) for one vsync-to-vsync
// frame, waits for the stream writer's capture_done_i, then re-arms or stops
// depending on MODE. Also measures the vsync period in clocks.
//
// Ports:
//   wb_clk_i        clock, rising edge
//   wb_rst_i        synchronous active-high reset
//   wb_adr_i[4:0]   byte address, word decoded on [4:2]
//   wb_dat_i[31:0]  write data
//   wb_sel_i[3:0]   byte selects (any nonzero writes the full word)
//   wb_we_i         write enable
//   wb_cyc_i        bus cycle
//   wb_stb_i        strobe
//   wb_dat_o[31:0]  read data, valid with ack
//   wb_ack_o        acknowledge
//   wb_err_o        error for unmapped word addresses 5..7
//   frame_start_i   asynchronous camera vsync, active high
//   capture_done_i  one-cycle pulse: frame landed in memory
//   enable_o        stream gating mask, high while capturing
//   irq_o           level interrupt, DONE & IRQ_EN
module wb_capture_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned PERIOD_W    = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [4:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    input  logic        frame_start_i,
    input  logic        capture_done_i,
    output logic        enable_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARM       = 2'd1,
        CAPTURE   = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_NFR    = 3'd1;
    localparam logic [2:0] A_STAT   = 3'd2;
    localparam logic [2:0] A_FCNT   = 3'd3;
    localparam logic [2:0] A_PERIOD = 3'd4;

    localparam logic [1:0] M_SINGLE = 2'd0;
    localparam logic [1:0] M_NFRAME = 2'd1;
    localparam logic [1:0] M_SINGLE_ALT = 2'd3;

    state_t                 state;
    logic [1:0]             mode;
    logic                   irq_en;
    logic [CNT_W-1:0]       nframes;
    logic [CNT_W-1:0]       frame_cnt;
    logic                   done;
    logic                   overrun;
    logic                   stop_pend;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_prev;
    logic [PERIOD_W-1:0]    period_cnt;
    logic [PERIOD_W-1:0]    period_q;

    logic                   req;
    logic [2:0]             adr;
    logic                   bad_adr;
    logic                   wr;
    logic                   ctrl_wr;
    logic                   stat_wr;
    logic                   start_c;
    logic                   stop_c;
    logic                   busy;
    logic                   frame_edge;
    logic [CNT_W-1:0]       nframes_eff;
    logic [CNT_W-1:0]       frame_cnt_inc;
    logic                   last_frame;
    logic [31:0]            rd_data;
    logic                   unused_bits;

    // Bus decode: a new request is accepted only when no response is showing,
    // which gives the mandatory idle cycle between back-to-back responses.
    assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign adr     = wb_adr_i[4:2];
    assign bad_adr = (adr >= 3'd5);
    assign wr      = req & wb_we_i & (|wb_sel_i) & ~bad_adr;
    assign ctrl_wr = wr & (adr == A_CTRL);
    assign stat_wr = wr & (adr == A_STAT);
    assign start_c = ctrl_wr & wb_dat_i[0];
    assign stop_c  = ctrl_wr & wb_dat_i[1];
    assign busy    = (state != IDLE);

    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i};

    // Frame edge: rising edge of the synchronised vsync.
    assign frame_edge = sync[SYNC_STAGES-1] & ~sync_prev;

    // NFRAMES of 0 behaves as 1; frame counter saturates.
    assign nframes_eff   = (nframes == '0) ? CNT_W'(1) : nframes;
    assign frame_cnt_inc = (&frame_cnt) ? frame_cnt : frame_cnt + CNT_W'(1);
    assign last_frame    = (mode == M_SINGLE) | (mode == M_SINGLE_ALT)
                         | ((mode == M_NFRAME) & (frame_cnt_inc >= nframes_eff))
                         | stop_pend | stop_c;

    // Read mux
    always_comb begin
        rd_data = '0;
        case (adr)
            A_CTRL:   rd_data = {27'd0, irq_en, mode, 2'b00};
            A_NFR:    rd_data = 32'(nframes);
            A_STAT:   rd_data = {29'd0, overrun, done, busy};
            A_FCNT:   rd_data = 32'(frame_cnt);
            A_PERIOD: rd_data = 32'(period_q);
            default:  rd_data = '0;
        endcase
    end

    // Registered single-cycle bus response
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req & ~bad_adr;
            wb_err_o <= req & bad_adr;
            wb_dat_o <= (req & ~bad_adr & ~wb_we_i) ? rd_data : '0;
        end
    end

    // Configuration registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            mode    <= 2'd0;
            irq_en  <= 1'b0;
            nframes <= '0;
        end else begin
            if (ctrl_wr) begin
                mode   <= wb_dat_i[3:2];
                irq_en <= wb_dat_i[4];
            end
            if (wr & (adr == A_NFR)) begin
                nframes <= wb_dat_i[CNT_W-1:0];
            end
        end
    end

    // vsync synchroniser, edge detect and period measurement
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync       <= '0;
            sync_prev  <= 1'b0;
            period_cnt <= '0;
            period_q   <= '0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], frame_start_i};
            sync_prev <= sync[SYNC_STAGES-1];
            if (frame_edge) begin
                period_q   <= period_cnt;
                period_cnt <= PERIOD_W'(1);
            end else if (~&period_cnt) begin
                period_cnt <= period_cnt + PERIOD_W'(1);
            end
        end
    end

    // Capture sequencer; enable_o is set/cleared on every transition into or
    // out of CAPTURE so it tracks the state exactly.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            enable_o  <= 1'b0;
            irq_o     <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            stop_pend <= 1'b0;
            frame_cnt <= '0;
        end else begin
            irq_o <= done & irq_en;
            if (stat_wr & wb_dat_i[1]) done    <= 1'b0;
            if (stat_wr & wb_dat_i[2]) overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_c) begin
                        state     <= ARM;
                        frame_cnt <= '0;
                        done      <= 1'b0;
                        stop_pend <= 1'b0;
                    end
                end
                ARM: begin
                    if (stop_c) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else if (frame_edge) begin
                        state    <= CAPTURE;
                        enable_o <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (stop_c) stop_pend <= 1'b1;
                    if (frame_edge) begin
                        state    <= WAIT_DONE;
                        enable_o <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (capture_done_i) begin
                        frame_cnt <= frame_cnt_inc;
                        if (last_frame) begin
                            state     <= IDLE;
                            done      <= 1'b1;
                            stop_pend <= 1'b0;
                        end else if (frame_edge) begin
                            // Edge coincident with completion: don't lose it.
                            state    <= CAPTURE;
                            enable_o <= 1'b1;
                        end else begin
                            state <= ARM;
                        end
                    end else begin
                        if (stop_c) stop_pend <= 1'b1;
                        if (frame_edge) overrun <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    enable_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_capture_ctrl.sv
module tb_wb_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  adr = '0;
    logic [31:0] dat_w = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    logic        fs = 1'b0;
    logic        cd = 1'b0;
    logic        en;
    logic        irq;

    always #5 clk = ~clk;

    wb_capture_ctrl dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wb_adr_i       (adr),
        .wb_dat_i       (dat_w),
        .wb_sel_i       (sel),
        .wb_we_i        (we),
        .wb_cyc_i       (cyc),
        .wb_stb_i       (stb),
        .wb_dat_o       (dat_r),
        .wb_ack_o       (ack),
        .wb_err_o       (err),
        .frame_start_i  (fs),
        .capture_done_i (cd),
        .enable_o       (en),
        .irq_o          (irq)
    );

    typedef struct {
        bit          chk_d;
        logic [31:0] d;
        logic        e;
        string       nm;
    } bus_exp_t;

    typedef struct {
        int    id;
        logic  v;
        string nm;
    } sig_exp_t;

    bus_exp_t bq[$];
    sig_exp_t sq[$];
    int       n_cmp = 0;
    int       n_bad = 0;
    bit       finish_req = 1'b0;

    bus_exp_t be;
    sig_exp_t se;
    logic     act;

    // Monitor: pops an expectation for every bus response and evaluates any
    // pending output-level expectations.
    always @(negedge clk) begin
        if (ack || err) begin
            if (bq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_response: ack=%0b err=%0b, required no response", ack, err);
            end else begin
                be = bq.pop_front();
                n_cmp++;
                if (err !== be.e || ack !== !be.e || (be.chk_d && dat_r !== be.d)) begin
                    n_bad++;
                    $display("FAIL %s: ack=%0b err=%0b data=0x%08h, required err=%0b data=0x%08h",
                             be.nm, ack, err, dat_r, be.e, be.d);
                end
            end
        end
        while (sq.size() > 0) begin
            se = sq.pop_front();
            case (se.id)
                0:       act = en;
                1:       act = irq;
                2:       act = ack;
                default: act = err;
            endcase
            n_cmp++;
            if (act !== se.v) begin
                n_bad++;
                $display("FAIL %s: got %0b, required %0b", se.nm, act, se.v);
            end
        end
        if (finish_req) begin
            n_cmp++;
            if (bq.size() != 0) begin
                n_bad++;
                $display("FAIL missing_response: %0d bus responses never arrived, required 0", bq.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic expect_sig(input int id, input logic v, input string nm);
        sig_exp_t s;
        s.id = id;
        s.v  = v;
        s.nm = nm;
        sq.push_back(s);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input bit w, input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit chk, input logic [31:0] exp,
                       input logic e, input string nm);
        bus_exp_t x;
        @(negedge clk);
        x.chk_d = chk;
        x.d     = exp;
        x.e     = e;
        x.nm    = nm;
        bq.push_back(x);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = w;
        adr   = a;
        dat_w = d;
        sel   = s;
        @(negedge clk);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus(1'b1, a, d, 4'hF, 1'b0, 32'd0, 1'b0, "write_ack");
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
        bus(1'b0, a, 32'd0, 4'hF, 1'b1, exp, 1'b0, nm);
    endtask

    // vsync pulse; checks enable_o just before and just after the frame edge
    // takes effect (third rising clock after the input rises).
    task automatic vsync(input logic b, input logic a, input bit with_done, input string nm);
        @(negedge clk);
        fs = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_sig(0, b, {nm, "_en_pre"});
        @(negedge clk);
        if (with_done) cd = 1'b1;
        @(posedge clk);
        #1;
        expect_sig(0, a, {nm, "_en_post"});
        @(negedge clk);
        fs = 1'b0;
        cd = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic cdone();
        @(negedge clk);
        cd = 1'b1;
        @(negedge clk);
        cd = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_and_check(input string nm);
        @(negedge clk);
        rst = 1'b1;
        after_edge();
        expect_sig(0, 1'b0, {nm, "_enable"});
        expect_sig(1, 1'b0, {nm, "_irq"});
        expect_sig(2, 1'b0, {nm, "_ack"});
        expect_sig(3, 1'b0, {nm, "_err"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        reset_and_check("reset");
        rd(5'h08, 32'h0, "rst_status");
        rd(5'h0C, 32'h0, "rst_frame_cnt");
        rd(5'h10, 32'h0, "rst_period");
        rd(5'h00, 32'h0, "rst_ctrl");

        // Single capture with IRQ_EN
        wr(5'h00, 32'h11);
        rd(5'h08, 32'h1, "single_busy");
        vsync(1'b0, 1'b1, 1'b0, "single_f0");
        vsync(1'b1, 1'b0, 1'b0, "single_f1");
        cdone();
        rd(5'h08, 32'h2, "single_status");
        rd(5'h0C, 32'h1, "single_frame_cnt");
        after_edge();
        expect_sig(1, 1'b1, "single_irq_set");

        // W1C DONE drops irq
        wr(5'h08, 32'h2);
        rd(5'h08, 32'h0, "w1c_status");
        after_edge();
        expect_sig(1, 1'b0, "w1c_irq_clear");

        // Unmapped addresses and sel=0 writes
        bus(1'b0, 5'h14, 32'd0, 4'hF, 1'b1, 32'h0, 1'b1, "err_rd_0x14");
        bus(1'b1, 5'h1C, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 1'b1, "err_wr_0x1C");
        bus(1'b1, 5'h04, 32'd5, 4'h0, 1'b0, 32'h0, 1'b0, "wr_sel0_ack");
        rd(5'h04, 32'h0, "sel0_no_effect");

        // N-frame, NFRAMES=3
        bus(1'b1, 5'h04, 32'd3, 4'h1, 1'b0, 32'h0, 1'b0, "wr_nframes");
        rd(5'h04, 32'd3, "nframes_rb");
        wr(5'h00, 32'h05);
        for (int i = 0; i < 3; i++) begin
            vsync(1'b0, 1'b1, 1'b0, "nf_open");
            vsync(1'b1, 1'b0, 1'b0, "nf_close");
            cdone();
            rd(5'h0C, 32'(i + 1), "nf_frame_cnt");
            rd(5'h08, (i == 2) ? 32'h2 : 32'h1, "nf_status");
        end
        rd(5'h00, 32'h04, "nf_ctrl_rb");
        after_edge();
        expect_sig(1, 1'b0, "nf_irq_masked");

        // N-frame, NFRAMES=0 behaves as one frame; START clears DONE
        wr(5'h04, 32'd0);
        wr(5'h00, 32'h05);
        rd(5'h08, 32'h1, "nf0_start_clears_done");
        vsync(1'b0, 1'b1, 1'b0, "nf0_open");
        vsync(1'b1, 1'b0, 1'b0, "nf0_close");
        cdone();
        rd(5'h08, 32'h2, "nf0_status");
        rd(5'h0C, 32'h1, "nf0_frame_cnt");

        // Continuous: overrun, then coincident edge+done, then STOP mid-CAPTURE
        wr(5'h00, 32'h09);
        vsync(1'b0, 1'b1, 1'b0, "cont_open");
        vsync(1'b1, 1'b0, 1'b0, "cont_close");
        vsync(1'b0, 1'b0, 1'b0, "ovr_edge");
        rd(5'h08, 32'h5, "ovr_status");
        vsync(1'b0, 1'b1, 1'b1, "coincide");
        rd(5'h0C, 32'h1, "coincide_frame_cnt");
        wr(5'h00, 32'h0A);
        after_edge();
        expect_sig(0, 1'b1, "stop_cap_still_enabled");
        rd(5'h08, 32'h5, "stop_cap_busy");
        vsync(1'b1, 1'b0, 1'b0, "stop_cap_close");
        cdone();
        rd(5'h08, 32'h6, "stop_cap_status");
        rd(5'h0C, 32'h2, "stop_cap_frame_cnt");
        wr(5'h08, 32'h4);
        rd(5'h08, 32'h2, "w1c_overrun");

        // STOP in ARM
        wr(5'h00, 32'h09);
        wr(5'h00, 32'h0A);
        rd(5'h08, 32'h2, "stop_arm_status");

        // START while busy is ignored
        wr(5'h00, 32'h09);
        vsync(1'b0, 1'b1, 1'b0, "busy_open");
        vsync(1'b1, 1'b0, 1'b0, "busy_close");
        cdone();
        wr(5'h00, 32'h09);
        rd(5'h0C, 32'h1, "start_busy_frame_cnt");
        rd(5'h08, 32'h1, "start_busy_status");
        wr(5'h00, 32'h0A);
        rd(5'h08, 32'h2, "idle_after_stop");

        // Period: vsync every 1000 clocks
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            fs = 1'b1;
            repeat (3) @(negedge clk);
            fs = 1'b0;
            repeat (996) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        rd(5'h10, 32'd1000, "period_1000");

        // Reset during CAPTURE with a pending STOP
        wr(5'h00, 32'h19);
        vsync(1'b0, 1'b1, 1'b0, "rst_cap_open");
        wr(5'h00, 32'h1A);
        reset_and_check("reset_mid_capture");
        rd(5'h08, 32'h0, "post_rst_status");
        rd(5'h10, 32'h0, "post_rst_period");
        rd(5'h00, 32'h0, "post_rst_ctrl");
        wr(5'h00, 32'h09);
        vsync(1'b0, 1'b1, 1'b0, "post_rst_open");
        vsync(1'b1, 1'b0, 1'b0, "post_rst_close");
        cdone();
        rd(5'h08, 32'h1, "stop_discarded_status");

        repeat (3) @(negedge clk);
        after_edge();
        finish_req = 1'b1;
    end

endmodule

// File: doc/wb_capture_ctrl.md
WB_CAPTURE_CTRL -- requirements
Module: wb_capture_ctrl

Interface
REQ-001 The block SHALL provide parameter CNT_W, default 16, as the width of the frame target and frame counter.
REQ-002 The block SHALL provide parameter PERIOD_W, default 32, as the width of the frame-period counter.
REQ-003 The block SHALL provide parameter SYNC_STAGES, default 2, as the synchroniser depth on frame_start_i (minimum 2).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
- wb_clk_i  in  1  clock; all logic on its rising edge.
- wb_rst_i  in  1  synchronous active-high reset.
- wb_adr_i  in  5  byte address; decoded on [4:2].
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  error, for unmapped addresses.
- frame_start_i  in  1  asynchronous camera vsync, active high.
- capture_done_i  in  1  one-cycle pulse from the stream writer when a frame has landed in memory.
- enable_o  out  1  stream gating mask.
- irq_o  out  1  level interrupt.

Function
REQ-005 The bus response SHALL be single-cycle registered: ack (or err) is asserted the cycle after cyc&stb and is held low for one cycle before it can be asserted again; read data is valid with ack.
REQ-006 The register map SHALL be:
- 0x00 CTRL: [0] START, write-1 self-clearing; [1] STOP, write-1 self-clearing; [3:2] MODE (0 single, 1 N-frame, 2 continuous, 3 treated as single); [4] IRQ_EN.
- 0x04 NFRAMES: [CNT_W-1:0].
- 0x08 STATUS: [0] BUSY (RO); [1] DONE (W1C); [2] OVERRUN (W1C).
- 0x0C FRAME_CNT (RO).
- 0x10 PERIOD (RO).
REQ-007 A write with wb_sel_i==0 SHALL have no effect; any nonzero wb_sel_i SHALL write the full word.
REQ-008 Reads and writes at wb_adr_i[4:2] of 5 to 7 SHALL assert wb_err_o instead of wb_ack_o and SHALL return 0.
REQ-009 Frame edge SHALL be defined as the rising edge of frame_start_i after SYNC_STAGES flops plus an edge-detect flop, giving SYNC_STAGES+1 cycles of latency.
REQ-010 The period counter SHALL increment every cycle, saturate at all-ones, and on a frame edge load PERIOD with its current value and restart at 1.
REQ-011 The FSM SHALL have states IDLE, ARM, CAPTURE and WAIT_DONE; BUSY SHALL be 1 in any state other than IDLE.
REQ-012 In IDLE, START SHALL clear FRAME_CNT, clear DONE and go to ARM; START in any other state SHALL be ignored.
REQ-013 In ARM, a frame edge SHALL go to CAPTURE, and STOP SHALL go to IDLE and set DONE.
REQ-014 enable_o SHALL be registered and equal 1 exactly while in CAPTURE.
REQ-015 In CAPTURE, the next frame edge SHALL go to WAIT_DONE.
REQ-016 In WAIT_DONE, capture_done_i SHALL increment FRAME_CNT (saturating).
REQ-017 The exit from WAIT_DONE on capture_done_i SHALL be:
- to IDLE with DONE set, if MODE is single, or MODE is N-frame and the new FRAME_CNT >= max(NFRAMES,1), or a STOP was latched;
- otherwise to ARM.
REQ-018 A STOP received in CAPTURE or WAIT_DONE SHALL be latched, and the current frame SHALL complete.
REQ-019 A frame edge in WAIT_DONE without capture_done_i SHALL set OVERRUN and leave the state unchanged.
REQ-020 A frame edge coincident with capture_done_i when the next state is ARM SHALL go directly to CAPTURE, so the edge is not lost.
REQ-021 capture_done_i outside WAIT_DONE SHALL be ignored.
REQ-022 irq_o SHALL equal DONE & IRQ_EN and be registered.

Reset
REQ-023 On wb_rst_i, all outputs and registers SHALL be 0 and the FSM SHALL be in IDLE: enable_o=0, irq_o=0, wb_ack_o=0, wb_err_o=0, PERIOD=0, synchroniser flops=0.
REQ-024 Reset asserted mid-capture SHALL drop enable_o the cycle after reset is sampled, and any pending STOP SHALL be discarded.

Verification
REQ-025 Single capture: MODE=0, START, vsync edges at t0 and t1, then capture_done -> enable_o high from t0+3 to t1+3, then FRAME_CNT=1, DONE=1, and irq_o=1 only if IRQ_EN=1.
REQ-026 N-frame: MODE=1, NFRAMES=3, with a capture_done after each frame -> three CAPTURE windows, FRAME_CNT=3, then IDLE; NFRAMES=0 -> one frame.
REQ-027 Overrun and coincidence: delay capture_done past the next edge -> OVERRUN=1; in continuous mode, edge in the same cycle as capture_done -> CAPTURE entered with no frame skipped.
REQ-028 STOP: STOP in ARM -> IDLE next cycle with DONE=1; STOP mid-CAPTURE -> the frame completes, then IDLE after capture_done.
REQ-029 Bus: read at 0x14 -> wb_err_o=1 and data 0; W1C of 0x2 to STATUS clears DONE and drops irq_o; START while BUSY has no effect.
REQ-030 Period and reset: vsync every 1000 clocks -> PERIOD=1000; reset during CAPTURE -> all outputs 0 the next cycle.
